// File: rtl/servant_spi_ram_ctrl.sv
// SPI slave (mode 0) that bridges READ 0x03 / WRITE 0x02 transactions onto a byte-wide RAM port.
// Optional macro SERVANT_SPI_RAM_CTRL_RDSR_EN adds command 0x05, which returns the mode byte 8'h40.
//
// state  | meaning
// IDLE   | waiting for an armed cs_n falling edge
// CMD    | shifting in the 8-bit command byte
// ADDR   | shifting in the 16-bit address, keeping the low aw bits
// WDATA  | shifting in write bytes, one RAM write per complete byte
// RDATA  | shifting out RAM bytes (or the mode byte) on MISO
// IGNORE | unknown command, swallow bits until cs_n rises
module servant_spi_ram_ctrl #(
    parameter int aw = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_spi_cs_n,
    input  logic          i_spi_sck,
    input  logic          i_spi_mosi,
    output logic          o_spi_miso,
    output logic [aw-1:0] o_ram_addr,
    output logic [7:0]    o_ram_wdata,
    output logic          o_ram_we_n,
    output logic          o_ram_re,
    input  logic [7:0]    i_ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] MODE_BYTE = 8'h40;

    logic [1:0]    rst_sync_q, rst_sync_d;
    logic          rst_int_n;

    logic          cs_meta_q, cs_meta_d, cs_s_q, cs_s_d, cs_prev_q, cs_prev_d;
    logic          sck_meta_q, sck_meta_d, sck_s_q, sck_s_d, sck_prev_q, sck_prev_d;
    logic          mosi_meta_q, mosi_meta_d, mosi_s_q, mosi_s_d;
    logic [1:0]    vld_q, vld_d;
    logic          armed_q, armed_d;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [14:0]   sr_q, sr_d;
    logic [aw-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          ld_q, ld_d;
    logic          is_rd_q, is_rd_d;
    logic          rdsr_q, rdsr_d;
    logic [7:0]    miso_sr_q, miso_sr_d;
    logic          miso_q, miso_d;

    logic          sck_rise, sck_fall, cs_fall;
    logic [15:0]   sr_new;
    logic [3:0]    cnt_inc;

    // Reset asserts asynchronously but releases on a clock edge.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    always_comb begin
        cs_meta_d   = i_spi_cs_n;
        cs_s_d      = cs_meta_q;
        cs_prev_d   = cs_s_q;
        sck_meta_d  = i_spi_sck;
        sck_s_d     = sck_meta_q;
        sck_prev_d  = sck_s_q;
        mosi_meta_d = i_spi_mosi;
        mosi_s_d    = mosi_meta_q;
        vld_d       = {vld_q[0], 1'b1};
        // Only a cs_n that has been seen high after reset may start a transaction.
        armed_d     = armed_q | (vld_q[1] & cs_s_q);

        sck_rise = sck_s_q & ~sck_prev_q;
        sck_fall = ~sck_s_q & sck_prev_q;
        cs_fall  = armed_q & cs_prev_q & ~cs_s_q;
        sr_new   = {sr_q, mosi_s_q};
        cnt_inc  = cnt_q + 4'd1;

        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        ld_d      = 1'b0;
        is_rd_d   = is_rd_q;
        rdsr_d    = rdsr_q;
        miso_sr_d = miso_sr_q;
        miso_d    = miso_q;

        // Strobe cycles: the RAM has seen the current address, so advance it.
        if (ld_q) begin
            miso_sr_d = rdsr_q ? MODE_BYTE : i_ram_rdata;
            if (!rdsr_q) addr_d = addr_q + aw'(1);
        end
        if (we_q) addr_d = addr_q + aw'(1);

        if (state_q == IDLE) begin
            miso_d = 1'b0;
            if (cs_fall) begin
                state_d = CMD;
                cnt_d   = 4'd0;
                rdsr_d  = 1'b0;
            end
        end else if (cs_s_q) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                CMD: begin
                    if (sck_rise) begin
                        sr_d  = sr_new[14:0];
                        cnt_d = cnt_inc;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            case (sr_new[7:0])
                                CMD_READ: begin
                                    state_d = ADDR;
                                    is_rd_d = 1'b1;
                                end
                                CMD_WRITE: begin
                                    state_d = ADDR;
                                    is_rd_d = 1'b0;
                                end
`ifdef SERVANT_SPI_RAM_CTRL_RDSR_EN
                                CMD_RDSR: begin
                                    state_d = RDATA;
                                    rdsr_d  = 1'b1;
                                    ld_d    = 1'b1;
                                end
`endif
                                default: state_d = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        sr_d  = sr_new[14:0];
                        cnt_d = cnt_inc;
                        if (cnt_q == 4'd15) begin
                            cnt_d  = 4'd0;
                            addr_d = sr_new[aw-1:0];
                            if (is_rd_q) begin
                                state_d = RDATA;
                                ld_d    = 1'b1;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sck_rise) begin
                        sr_d  = sr_new[14:0];
                        cnt_d = cnt_inc;
                        if (cnt_q == 4'd7) begin
                            cnt_d   = 4'd0;
                            wdata_d = sr_new[7:0];
                            we_d    = 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (sck_fall) begin
                        miso_d    = miso_sr_q[7];
                        miso_sr_d = {miso_sr_q[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        cnt_d = cnt_inc;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            ld_d  = 1'b1;
                        end
                    end
                end
                IGNORE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cs_meta_q   <= 1'b1;
            cs_s_q      <= 1'b1;
            cs_prev_q   <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_s_q     <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_s_q    <= 1'b0;
            vld_q       <= 2'b00;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            sr_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            we_q        <= 1'b0;
            ld_q        <= 1'b0;
            is_rd_q     <= 1'b0;
            rdsr_q      <= 1'b0;
            miso_sr_q   <= 8'h00;
            miso_q      <= 1'b0;
        end else begin
            cs_meta_q   <= cs_meta_d;
            cs_s_q      <= cs_s_d;
            cs_prev_q   <= cs_prev_d;
            sck_meta_q  <= sck_meta_d;
            sck_s_q     <= sck_s_d;
            sck_prev_q  <= sck_prev_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_s_q    <= mosi_s_d;
            vld_q       <= vld_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            ld_q        <= ld_d;
            is_rd_q     <= is_rd_d;
            rdsr_q      <= rdsr_d;
            miso_sr_q   <= miso_sr_d;
            miso_q      <= miso_d;
        end
    end

    assign o_spi_miso  = miso_q;
    assign o_ram_addr  = addr_q;
    assign o_ram_wdata = wdata_q;
    assign o_ram_we_n  = ~we_q;
    assign o_ram_re    = ld_q & ~rdsr_q;

endmodule

// File: tb/tb_servant_spi_ram_ctrl.sv
// Directed bench for servant_spi_ram_ctrl: a transaction-level model predicts RAM strobes and MISO bytes,
// and a per-cycle monitor matches every strobe the DUT issues against the predicted queue.
`timescale 1ns/1ps
module tb_servant_spi_ram_ctrl;

    localparam int HALF = 50;
`ifdef SERVANT_SPI_RAM_CTRL_RDSR_EN
    localparam logic [7:0] RDSR_EXP = 8'h40;
`else
    localparam logic [7:0] RDSR_EXP = 8'h00;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_spi_cs_n;
    logic        i_spi_sck;
    logic        i_spi_mosi;
    logic        o_spi_miso;
    logic [15:0] o_ram_addr;
    logic [7:0]  o_ram_wdata;
    logic        o_ram_we_n;
    logic        o_ram_re;
    logic [7:0]  i_ram_rdata;

    servant_spi_ram_ctrl #(.aw(16)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_spi_cs_n  (i_spi_cs_n),
        .i_spi_sck   (i_spi_sck),
        .i_spi_mosi  (i_spi_mosi),
        .o_spi_miso  (o_spi_miso),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
        .o_ram_we_n  (o_ram_we_n),
        .o_ram_re    (o_ram_re),
        .i_ram_rdata (i_ram_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Bench-side RAM attached to the DUT.
    logic [7:0]  mem [0:65535];
    logic        pre_en;
    logic [15:0] pre_a;
    logic [7:0]  pre_d;

    always @(posedge i_clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        else if (!o_ram_we_n) mem[o_ram_addr] <= o_ram_wdata;
    end
    assign i_ram_rdata = mem[o_ram_addr];

    // Reference model state.
    typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [7:0]  ref_mem [0:65535];
    logic [7:0]  got [0:3];
    wr_t         w_cur;
    logic [15:0] r_cur;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
    endtask

    // Every RAM strobe must match the head of the predicted queue.
    always @(negedge i_clk) begin
        if (i_rst_n && (!o_ram_we_n || o_ram_re)) begin
            if (!o_ram_we_n && o_ram_re) begin
                n_checks++;
                $display("FAIL strobe_excl: we_n=%b re=%b at addr %0h", o_ram_we_n, o_ram_re, o_ram_addr);
            end else if (!o_ram_we_n) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexp_write: addr %0h data %0h, no write expected", o_ram_addr, o_ram_wdata);
                end else begin
                    w_cur = exp_wr.pop_front();
                    chk("wr_addr", 32'(o_ram_addr), 32'(w_cur.a));
                    chk("wr_data", 32'(o_ram_wdata), 32'(w_cur.d));
                end
            end else begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexp_read: addr %0h, no read expected", o_ram_addr);
                end else begin
                    r_cur = exp_rd.pop_front();
                    chk("rd_addr", 32'(o_ram_addr), 32'(r_cur));
                end
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_en = 1'b1;
        @(posedge i_clk);
        #1;
        pre_en     = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            i_spi_mosi = tx[i];
            #(HALF);
            rx[i] = o_spi_miso;
            i_spi_sck = 1'b1;
            #(HALF);
            i_spi_sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        i_spi_cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic cs_end();
        #(HALF);
        i_spi_cs_n = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] addr);
        logic [7:0] rx;
        spi_bits(cmd, 8, rx);
        chk("miso_idle_cmd", 32'(rx), 32'h0);
        spi_bits(addr[15:8], 8, rx);
        chk("miso_idle_addr_hi", 32'(rx), 32'h0);
        spi_bits(addr[7:0], 8, rx);
        chk("miso_idle_addr_lo", 32'(rx), 32'h0);
    endtask

    task automatic spi_write(input logic [15:0] addr, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0]  rx;
        logic [15:0] a1;
        a1 = addr + 16'd1;
        exp_wr.push_back('{a: addr, d: d0});
        exp_wr.push_back('{a: a1, d: d1});
        ref_mem[addr] = d0;
        ref_mem[a1]   = d1;
        cs_begin();
        send_hdr(8'h02, addr);
        spi_bits(d0, 8, rx);
        chk("miso_idle_wdata", 32'(rx), 32'h0);
        spi_bits(d1, 8, rx);
        chk("miso_idle_wdata", 32'(rx), 32'h0);
        cs_end();
        chk("wr_queue_drained", 32'(exp_wr.size()), 32'h0);
    endtask

    // Reads n bytes; the model expects n+1 read strobes because the next byte is prefetched.
    task automatic spi_read(input logic [15:0] addr, input int n);
        logic [15:0] a;
        for (int i = 0; i <= n; i++) exp_rd.push_back(addr + 16'(i));
        cs_begin();
        send_hdr(8'h03, addr);
        for (int i = 0; i < n; i++) begin
            a = addr + 16'(i);
            spi_bits(8'h00, 8, got[i]);
            chk("rd_miso_byte", 32'(got[i]), 32'(ref_mem[a]));
        end
        cs_end();
        chk("rd_queue_drained", 32'(exp_rd.size()), 32'h0);
    endtask

    initial begin
        logic [7:0] rx;
        i_rst_n    = 1'b0;
        i_spi_cs_n = 1'b1;
        i_spi_sck  = 1'b0;
        i_spi_mosi = 1'b0;
        pre_en     = 1'b0;
        pre_a      = 16'h0;
        pre_d      = 8'h0;
        preload(16'h0010, 8'h11);
        preload(16'h0011, 8'h22);
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_addr", 32'(o_ram_addr), 32'h0);
        chk("rst_wdata", 32'(o_ram_wdata), 32'h0);
        chk("rst_we_n", 32'(o_ram_we_n), 32'h1);
        chk("rst_re", 32'(o_ram_re), 32'h0);
        chk("rst_miso", 32'(o_spi_miso), 32'h0);
        #2;
        i_rst_n = 1'b1;
        repeat (8) @(posedge i_clk);
        #1;

        // Write two bytes, then read them back over the preloaded values.
        spi_write(16'h0010, 8'hA5, 8'h3C);
        spi_read(16'h0010, 2);
        chk("read_lit_0", 32'(got[0]), 32'hA5);
        chk("read_lit_1", 32'(got[1]), 32'h3C);

        // Address wrap at the top of the 16-bit space.
        spi_write(16'hFFFF, 8'h5A, 8'hC3);
        spi_read(16'hFFFF, 2);
        chk("wrap_lit_0", 32'(got[0]), 32'h5A);
        chk("wrap_lit_1", 32'(got[1]), 32'hC3);

        // Partial byte: cs_n rises after 5 data bits, no write.
        cs_begin();
        send_hdr(8'h02, 16'h0010);
        spi_bits(8'hFF, 5, rx);
        cs_end();
        chk("partial_no_write", 32'(exp_wr.size()), 32'h0);
        spi_read(16'h0010, 1);
        chk("partial_old_value", 32'(got[0]), 32'hA5);

        // cs_n rises together with the 8th sck rise: cs_n wins.
        cs_begin();
        send_hdr(8'h02, 16'h0011);
        spi_bits(8'h00, 7, rx);
        i_spi_mosi = 1'b0;
        #(HALF);
        i_spi_sck  = 1'b1;
        i_spi_cs_n = 1'b1;
        #(HALF);
        i_spi_sck  = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        spi_read(16'h0011, 1);
        chk("coincident_old_value", 32'(got[0]), 32'h3C);

        // Unknown command.
        cs_begin();
        spi_bits(8'h9F, 8, rx);
        chk("ign_cmd_miso", 32'(rx), 32'h0);
        spi_bits(8'h12, 8, rx);
        chk("ign_miso_0", 32'(rx), 32'h0);
        spi_bits(8'h34, 8, rx);
        chk("ign_miso_1", 32'(rx), 32'h0);
        cs_end();

        // Mode register read (0x40 only when the option is built in).
        cs_begin();
        spi_bits(8'h05, 8, rx);
        chk("rdsr_cmd_miso", 32'(rx), 32'h0);
        spi_bits(8'h00, 8, rx);
        chk("rdsr_byte_0", 32'(rx), 32'(RDSR_EXP));
        spi_bits(8'h00, 8, rx);
        chk("rdsr_byte_1", 32'(rx), 32'(RDSR_EXP));
        cs_end();
        chk("no_strobes_wr", 32'(exp_wr.size()), 32'h0);
        chk("no_strobes_rd", 32'(exp_rd.size()), 32'h0);

        // Reset in the middle of a READ, with cs_n still low through release.
        exp_rd.push_back(16'h0010);
        cs_begin();
        send_hdr(8'h03, 16'h0010);
        spi_bits(8'h00, 3, rx);
        #7;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_addr", 32'(o_ram_addr), 32'h0);
        chk("midrst_wdata", 32'(o_ram_wdata), 32'h0);
        chk("midrst_we_n", 32'(o_ram_we_n), 32'h1);
        chk("midrst_re", 32'(o_ram_re), 32'h0);
        chk("midrst_miso", 32'(o_spi_miso), 32'h0);
        chk("midrst_entry_read", 32'(exp_rd.size()), 32'h0);
        repeat (4) @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
        spi_bits(8'h02, 8, rx);
        chk("stale_miso_0", 32'(rx), 32'h0);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h20, 8, rx);
        spi_bits(8'h77, 8, rx);
        spi_bits(8'h88, 8, rx);
        chk("stale_miso_1", 32'(rx), 32'h0);
        cs_end();
        chk("stale_no_write", 32'(exp_wr.size()), 32'h0);

        spi_read(16'h0010, 2);
        chk("post_rst_lit_0", 32'(got[0]), 32'hA5);
        chk("post_rst_lit_1", 32'(got[1]), 32'h3C);
        spi_write(16'h0100, 8'h69, 8'h96);
        spi_read(16'h0100, 2);
        chk("post_rst_lit_2", 32'(got[0]), 32'h69);
        chk("post_rst_lit_3", 32'(got[1]), 32'h96);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
